// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial pattern detector with saturating match counter
module seq_detect_param #(
    parameter int                PAT_W   = 4,
    parameter logic [PAT_W-1:0]  PATTERN = 4'b1101,
    parameter int                CNT_W   = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             en,
    input  logic             d_in,
    input  logic             overlap,
    input  logic             clear,
    output logic             found,
    output logic [CNT_W-1:0] match_count,
    output logic             sat
);

    // fill counts sampled bits up to PAT_W; it gates matching so that the
    // all-zero history after reset never looks like an all-zero pattern.
    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill_nxt;
    logic              found_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              sat_nxt;

    logic [PAT_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_step;
    logic              hit;
    logic              count_full;

    // Candidate history/fill after consuming d_in, and the match decision on them.
    always_comb begin
        shifted    = {hist[PAT_W-2:0], d_in};
        fill_step  = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        hit        = en && !clear && (shifted == PATTERN) && (fill_step == FILL_FULL);
        count_full = &match_count;
    end

    // Next-state selection: clear beats en; en=0 holds everything but drops found.
    always_comb begin
        hist_nxt  = hist;
        fill_nxt  = fill;
        found_nxt = 1'b0;
        count_nxt = match_count;
        sat_nxt   = sat;
        if (clear) begin
            hist_nxt  = '0;
            fill_nxt  = '0;
            count_nxt = '0;
            sat_nxt   = 1'b0;
        end else if (en) begin
            hist_nxt = shifted;
            if (hit) begin
                found_nxt = 1'b1;
                // Overlap keeps the window full so the tail can seed the next
                // match; non-overlap demands PAT_W fresh bits.
                fill_nxt  = overlap ? FILL_FULL : '0;
                if (count_full) begin
                    sat_nxt = 1'b1;
                end else begin
                    count_nxt = match_count + CNT_W'(1);
                end
            end else begin
                fill_nxt = fill_step;
            end
        end
    end

    // State and output registers, forced to zero immediately by rst.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            hist        <= '0;
            fill        <= '0;
            found       <= 1'b0;
            match_count <= '0;
            sat         <= 1'b0;
        end else begin
            hist        <= hist_nxt;
            fill        <= fill_nxt;
            found       <= found_nxt;
            match_count <= count_nxt;
            sat         <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - randomized self-checking bench for seq_detect_param
module tb_seq_detect_param;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst, en, d_in, overlap, clear;
    logic       found_a, found_b, found_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       sat_a, sat_b, sat_c;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8)) dut_a (
        .clock(clock), .rst(rst), .en(en), .d_in(d_in), .overlap(overlap), .clear(clear),
        .found(found_a), .match_count(cnt_a), .sat(sat_a));
    seq_detect_param #(.PAT_W(3), .PATTERN(3'b000), .CNT_W(8)) dut_b (
        .clock(clock), .rst(rst), .en(en), .d_in(d_in), .overlap(overlap), .clear(clear),
        .found(found_b), .match_count(cnt_b), .sat(sat_b));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(2)) dut_c (
        .clock(clock), .rst(rst), .en(en), .d_in(d_in), .overlap(overlap), .clear(clear),
        .found(found_c), .match_count(cnt_c), .sat(sat_c));

    logic        g_found[3];
    logic [31:0] g_cnt[3];
    logic        g_sat[3];
    assign g_found[0] = found_a;
    assign g_found[1] = found_b;
    assign g_found[2] = found_c;
    assign g_cnt[0]   = {24'd0, cnt_a};
    assign g_cnt[1]   = {24'd0, cnt_b};
    assign g_cnt[2]   = {30'd0, cnt_c};
    assign g_sat[0]   = sat_a;
    assign g_sat[1]   = sat_b;
    assign g_sat[2]   = sat_c;

    // Reference model: every bit accepted since the last reset/clear is kept in
    // one stream; each detector looks at the tail of the stream starting at its
    // own window start (moved forward after a non-overlapping match).
    int          pw[3]   = '{4, 3, 4};
    logic [31:0] pat[3]  = '{32'hD, 32'h0, 32'hF};
    int          cmax[3] = '{255, 255, 3};
    bit          stream[$];
    int          start[3];
    bit          e_found[3];
    int          e_cnt[3];
    bit          e_sat[3];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit tail_hit(input int i);
        int n;
        n = stream.size();
        if (n - start[i] < pw[i]) return 1'b0;
        for (int k = 0; k < pw[i]; k++)
            if (stream[n-1-k] != pat[i][k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        stream.delete();
        for (int i = 0; i < 3; i++) begin
            start[i] = 0; e_found[i] = 0; e_cnt[i] = 0; e_sat[i] = 0;
        end
    endtask

    task automatic model_edge(input bit e, input bit d, input bit ov, input bit clr);
        if (clr) begin
            model_reset();
        end else if (!e) begin
            for (int i = 0; i < 3; i++) e_found[i] = 0;
        end else begin
            stream.push_back(d);
            for (int i = 0; i < 3; i++) begin
                e_found[i] = tail_hit(i);
                if (e_found[i]) begin
                    if (e_cnt[i] == cmax[i]) e_sat[i] = 1;
                    else e_cnt[i]++;
                    if (!ov) start[i] = stream.size();
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.found%0d", tag, i), {31'd0, g_found[i]}, {31'd0, e_found[i]});
            chk($sformatf("%s.cnt%0d", tag, i), g_cnt[i], e_cnt[i]);
            chk($sformatf("%s.sat%0d", tag, i), {31'd0, g_sat[i]}, {31'd0, e_sat[i]});
        end
    endtask

    task automatic step(input string tag, input bit e, input bit d, input bit ov, input bit clr);
        @(negedge clock);
        en = e; d_in = d; overlap = ov; clear = clr;
        @(posedge clock);
        model_edge(e, d, ov, clr);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        en = 0; d_in = 0; clear = 0; rst = 1;
        model_reset();
        @(posedge clock);
        #1;
        check_all(tag);
        @(negedge clock);
        rst = 0;
    endtask

    bit seq7[7] = '{1, 1, 0, 1, 1, 0, 1};

    initial begin
        rst = 1; en = 0; d_in = 0; overlap = 0; clear = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all("reset");
        chk("reset_cnt_a", {24'd0, cnt_a}, 32'd0);

        // Overlapping 1101101: matches on bits 4 and 7
        do_reset("r1");
        for (int k = 0; k < 7; k++) begin
            step("ov1", 1, seq7[k], 1, 0);
            chk($sformatf("ov1_found_a_%0d", k), {31'd0, found_a}, (k == 3 || k == 6) ? 32'd1 : 32'd0);
        end
        chk("ov1_count", {24'd0, cnt_a}, 32'd2);

        // Non-overlapping: only bit 4
        do_reset("r2");
        for (int k = 0; k < 7; k++) begin
            step("ov0", 1, seq7[k], 0, 0);
            chk($sformatf("ov0_found_a_%0d", k), {31'd0, found_a}, (k == 3) ? 32'd1 : 32'd0);
        end
        chk("ov0_count", {24'd0, cnt_a}, 32'd1);

        // Idle gap inside the pattern
        do_reset("r3");
        step("gap", 1, 1, 1, 0);
        step("gap", 1, 1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step("gap", 0, 1, 1, 0);
            chk("gap_idle_found", {31'd0, found_a}, 32'd0);
        end
        step("gap", 1, 0, 1, 0);
        step("gap", 1, 1, 1, 0);
        chk("gap_found", {31'd0, found_a}, 32'd1);
        step("gap", 0, 1, 1, 0);
        chk("gap_no_stretch", {31'd0, found_a}, 32'd0);
        chk("gap_count", {24'd0, cnt_a}, 32'd1);

        // All-zero pattern right after reset
        do_reset("r4");
        for (int k = 0; k < 6; k++) begin
            step("zero", 1, 0, 1, 0);
            chk($sformatf("zero_found_b_%0d", k), {31'd0, found_b}, (k >= 2) ? 32'd1 : 32'd0);
        end

        // 2-bit counter saturation with 1111
        do_reset("r5");
        for (int k = 0; k < 10; k++) begin
            step("sat", 1, 1, 1, 0);
            chk($sformatf("sat_cnt_c_%0d", k), {30'd0, cnt_c}, (k < 3) ? 32'd0 : ((k - 2 > 3) ? 32'd3 : k - 2));
            chk($sformatf("sat_flag_c_%0d", k), {31'd0, sat_c}, (k >= 6) ? 32'd1 : 32'd0);
        end

        // Clear on the completing edge, then a clean match, then async reset
        do_reset("r6");
        step("clr", 1, 1, 1, 0);
        step("clr", 1, 1, 1, 0);
        step("clr", 1, 0, 1, 0);
        step("clr", 1, 1, 1, 1);
        chk("clr_found", {31'd0, found_a}, 32'd0);
        chk("clr_count", {24'd0, cnt_a}, 32'd0);
        step("clr", 1, 1, 1, 0);
        step("clr", 1, 1, 1, 0);
        step("clr", 1, 0, 1, 0);
        step("clr", 1, 1, 1, 0);
        chk("clr_after_count", {24'd0, cnt_a}, 32'd1);
        #2;
        rst = 1;
        model_reset();
        #1;
        chk("async_found", {31'd0, found_a}, 32'd0);
        chk("async_count", {24'd0, cnt_a}, 32'd0);
        check_all("async");
        @(negedge clock);
        rst = 0;

        // Randomized run against the model
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 1) == 1, $urandom_range(0, 59) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
